// File: rtl/reg8_arb_pkg.sv
// reg8_arb_pkg: shared types and helpers for the reg8_share_arb write arbiter.
//   state_t  - write sequencer states (IDLE -> LOAD -> ACK)
//   W_DEF    - default register/data width
//   NREQ_MAX - largest supported requester count
//   onehot() - index-to-one-hot decode, NREQ_MAX bits wide
package reg8_arb_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Bits at or above n are never set, so a stray index cannot alias
  // onto a requester that does not exist.
  function automatic logic [NREQ_MAX-1:0] onehot(input int idx, input int n);
    logic [NREQ_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ_MAX; i++)
      if (i == idx && i < n) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg8_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     - request vector
//   ptr     - highest-priority index (always < NREQ)
//   gnt_idx - first requesting index found searching ptr, ptr+1, ... mod NREQ
//   any     - at least one request present
module rr_pick
  import reg8_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  // One extra bit so ptr+k cannot overflow before the wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      // Explicit compare-and-subtract keeps non-power-of-two NREQ in range.
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/reg8_share_arb.sv
// reg8_share_arb: round-robin write arbiter owning one shared W-bit register.
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   req   - per-requester level write request
//   wdata - packed write data, requester i in [i*W +: W]
//   ack   - one-hot write-done pulse to the granted requester (state ACK)
//   q     - shared register contents
//   owner - index of last requester whose write completed
//   upd   - one-cycle pulse while q first shows new data
//   busy  - sequencer not in IDLE
module reg8_share_arb
  import reg8_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = W_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic [IW-1:0]     owner,
  output logic              upd,
  output logic              busy
);

  state_t                   state_q, state_d;
  logic [IW-1:0]            ptr_q, gidx_q;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;
  logic                     ld_ok;
  logic [NREQ-1:0][W-1:0]   wd_arr;
  logic [NREQ_MAX-1:0]      oh_full;
  logic                     unused_oh;

  assign wd_arr = wdata;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Only the granted requester is looked at in LOAD; dropping it aborts.
  assign ld_ok = (state_q == LOAD) && req[gidx_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = LOAD;
      LOAD:    state_d = ld_ok ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      q       <= '0;
      owner   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) gidx_q <= pick_idx;
      if (ld_ok) begin
        q     <= wd_arr[gidx_q];
        owner <= gidx_q;
        ptr_q <= (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
      end
    end
  end

  // Outputs are pure state decodes, so reset clears them without an edge.
  assign oh_full   = onehot(int'(gidx_q), NREQ);
  assign ack       = (state_q == ACK) ? oh_full[NREQ-1:0] : '0;
  assign upd       = (state_q == ACK);
  assign busy      = (state_q != IDLE);
  assign unused_oh = ^oh_full;

endmodule

// File: tb/tb_reg8_share_arb.sv
module tb_reg8_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        upd;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  reg8_share_arb #(.NREQ(4), .W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .upd   (upd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_q;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[7];

  // One full write: apply, wait for ack (bounded), check, release, check idle.
  task automatic run_vec(input vec_t v, input int id);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    @(negedge clk);
    req   = v.req;
    wdata = v.wdata;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        got = 1;
        lat = c;
      end else if (c == 1) begin
        chk($sformatf("v%0d_busy_load", id), {31'b0, busy}, 32'd1);
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d_ack_timeout: got no ack expected %0h", id, v.exp_ack);
    end else begin
      chk($sformatf("v%0d_latency", id), lat, 32'd2);
      chk($sformatf("v%0d_ack", id), {28'b0, ack}, {28'b0, v.exp_ack});
      chk($sformatf("v%0d_q", id), {24'b0, q}, {24'b0, v.exp_q});
      chk($sformatf("v%0d_owner", id), {30'b0, owner}, {30'b0, v.exp_owner});
      chk($sformatf("v%0d_upd", id), {31'b0, upd}, 32'd1);
    end
    req = 4'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ack_end", id), {28'b0, ack}, 32'd0);
    chk($sformatf("v%0d_upd_end", id), {31'b0, upd}, 32'd0);
    chk($sformatf("v%0d_busy_end", id), {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 4'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int na;
    // ptr walk from reset: 0 ->3 ->1 ->3 ->0 ->2 ->0 ->1
    vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 8'hA5, 2'd2};
    vecs[1] = '{4'b0101, 32'h00330011, 4'b0001, 8'h11, 2'd0};
    vecs[2] = '{4'b0101, 32'h00770055, 4'b0100, 8'h77, 2'd2};
    vecs[3] = '{4'b1010, 32'h99008800, 4'b1000, 8'h99, 2'd3};
    vecs[4] = '{4'b1010, 32'hBB00AA00, 4'b0010, 8'hAA, 2'd1};
    vecs[5] = '{4'b1001, 32'hDD0000CC, 4'b1000, 8'hDD, 2'd3};
    vecs[6] = '{4'b0001, 32'h000000EE, 4'b0001, 8'hEE, 2'd0};

    rst   = 1'b0;
    req   = 4'b0;
    wdata = 32'h0;
    #12;
    chk("rst0_q", {24'b0, q}, 32'd0);
    chk("rst0_busy", {31'b0, busy}, 32'd0);
    chk("rst0_ack", {28'b0, ack}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Asynchronous reset mid-cycle with random inputs.
    @(negedge clk);
    req   = 4'($urandom_range(1, 15));
    wdata = $urandom;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_q", {24'b0, q}, 32'd0);
    chk("arst_owner", {30'b0, owner}, 32'd0);
    chk("arst_ack", {28'b0, ack}, 32'd0);
    chk("arst_upd", {31'b0, upd}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    req = 4'b0;
    rst = 1'b1;

    // Full contention from ptr=0: acks on cycles 2,5,8,11,14.
    @(negedge clk);
    req   = 4'b1111;
    wdata = 32'h44332211;
    na = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        chk($sformatf("cont%0d_cycle", na), k, 32'(2 + 3*na));
        chk($sformatf("cont%0d_ack", na), {28'b0, ack}, 32'(1 << (na % 4)));
        chk($sformatf("cont%0d_q", na), {24'b0, q}, 32'(8'h11 * ((na % 4) + 1)));
        na++;
      end
    end
    chk("cont_count", na, 32'd5);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // Abort: leaves ptr at 3, so the follow-up 0101 must go to requester 0.
    do_reset();
    run_vec(vecs[0], 10);
    @(negedge clk);
    req   = 4'b0010;
    wdata = 32'h00005A00;
    @(negedge clk);
    chk("abort_busy_load", {31'b0, busy}, 32'd1);
    req = 4'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ack", {28'b0, ack}, 32'd0);
    chk("abort_upd", {31'b0, upd}, 32'd0);
    chk("abort_q", {24'b0, q}, 32'hA5);
    chk("abort_owner", {30'b0, owner}, 32'd2);
    run_vec(vecs[1], 11);

    // Reset while in LOAD: write must never land.
    @(negedge clk);
    req   = 4'b0001;
    wdata = 32'h000000FF;
    @(negedge clk);
    chk("rload_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rload_q_now", {24'b0, q}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rload_hold%0d_ack", c), {28'b0, ack}, 32'd0);
      chk($sformatf("rload_hold%0d_busy", c), {31'b0, busy}, 32'd0);
      chk($sformatf("rload_hold%0d_q", c), {24'b0, q}, 32'd0);
    end
    req = 4'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rload_post%0d_ack", c), {28'b0, ack}, 32'd0);
      chk($sformatf("rload_post%0d_upd", c), {31'b0, upd}, 32'd0);
      chk($sformatf("rload_post%0d_q", c), {24'b0, q}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
